// File: rtl/gbf_fill_pkg.sv
// gbf_fill_pkg: shared FSM state type, requester indices and helpers for the GBF fill arbiter
package gbf_fill_pkg;

    localparam int NREQ = 4;

    localparam logic [1:0] ACTV1 = 2'd0;
    localparam logic [1:0] ACTV2 = 2'd1;
    localparam logic [1:0] WGT1  = 2'd2;
    localparam logic [1:0] WGT2  = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way requester pick; round-robin from ptr, or weights-first fixed priority when GBF_FILL_WGT_FIRST_EN is defined
module rr_arbiter4
    import gbf_fill_pkg::*;
(
    input  logic [NREQ-1:0] eligible,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      gid
);

`ifdef GBF_FILL_WGT_FIRST_EN
    // fixed priority: weight banks ahead of activation banks so weights never starve
    always_comb begin
        gid = eligible[WGT1]  ? WGT1  :
              eligible[WGT2]  ? WGT2  :
              eligible[ACTV1] ? ACTV1 : ACTV2;
    end
`else
    logic [NREQ-1:0] rot;
    logic [1:0]      off;

    // rotate so the pointer position sits at bit 0, take the first set bit, rotate back
    always_comb begin
        rot = 4'({eligible, eligible} >> ptr);
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : {rot[3], rot[3]};
        gid = ptr + off;
    end
`endif

    assign grant = |eligible ? onehot(gid) : '0;

endmodule

// File: rtl/gbf_fill_arbiter.sv
// gbf_fill_arbiter: schedules full-bank refills of the four GBF banks from one DMA stream (GBF_FILL_WGT_FIRST_EN selects weights-first priority)
module gbf_fill_arbiter
    import gbf_fill_pkg::*;
#(
    parameter int GBF_DATA_BITWIDTH = 512,
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int GBF_DEPTH         = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              need_data,
    input  logic                         fill_stop,
    output logic                         dma_req,
    output logic [1:0]                   dma_req_id,
    input  logic                         dma_req_ack,
    input  logic                         dma_valid,
    input  logic [GBF_DATA_BITWIDTH-1:0] dma_data,
    output logic                         dma_ready,
    output logic [NREQ-1:0]              en_a,
    output logic [NREQ-1:0]              we_a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr_a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data_a,
    output logic [NREQ-1:0]              buf_ready,
    output logic                         actv_data_avail,
    output logic                         wgt_data_avail,
    output logic                         busy
);

    state_t                       state, state_nx;
    logic [1:0]                   gid, ptr, arb_gid;
    logic [NREQ-1:0]              filled, eligible, arb_grant, set_fill;
    logic [GBF_ADDR_BITWIDTH-1:0] cnt;
    logic                         grant_now, beat, last_beat;

    assign eligible  = need_data & ~filled;
    assign grant_now = (state == IDLE) && (|arb_grant) && !fill_stop;
    assign beat      = dma_valid & dma_ready;
    assign last_beat = beat && (cnt == GBF_ADDR_BITWIDTH'(GBF_DEPTH - 1));
    assign set_fill  = (state == DONE) ? onehot(gid) : '0;

    assign dma_req         = state == REQ;
    assign dma_req_id      = gid;
    assign dma_ready       = state == XFER;
    assign busy            = state != IDLE;
    assign actv_data_avail = filled[ACTV1] | filled[ACTV2];
    assign wgt_data_avail  = filled[WGT1]  | filled[WGT2];

    rr_arbiter4 u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (arb_grant),
        .gid      (arb_gid)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: grant -> DMA request -> GBF_DEPTH-word burst -> one-cycle completion
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_now) state_nx = REQ;
            REQ:     if (dma_req_ack) state_nx = XFER;
            XFER:    if (last_beat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // grant bookkeeping, burst counter, registered write port and fill flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gid       <= '0;
            ptr       <= '0;
            cnt       <= '0;
            filled    <= '0;
            en_a      <= '0;
            we_a      <= '0;
            addr_a    <= '0;
            w_data_a  <= '0;
            buf_ready <= '0;
        end else begin
            if (grant_now) begin
                gid <= arb_gid;
                ptr <= arb_gid + 2'd1;
            end
            if (state == REQ && dma_req_ack) cnt <= '0;
            else if (beat)                   cnt <= cnt + GBF_ADDR_BITWIDTH'(1);
            en_a <= beat ? onehot(gid) : '0;
            we_a <= beat ? onehot(gid) : '0;
            if (beat) begin
                addr_a   <= cnt;
                w_data_a <= dma_data;
            end
            buf_ready <= set_fill;
            filled    <= set_fill | (filled & need_data);
        end
    end

endmodule

// File: doc/gbf_fill_arbiter.md
# gbf_fill_arbiter

Fill scheduler for the double-buffered activation and weight global buffers (GBFs). It arbitrates four refill requesters (actv buf1/buf2, wgt buf1/buf2) for one shared upstream DMA stream. Each grant moves one full-buffer burst into the port-a write side of the selected GBF bank, then reports the bank ready to the GBF controller. It sits between the off-chip DMA and the GBF port-a inputs of the GBF/PE-array top.

## Interface
- GBF_DATA_BITWIDTH, 512, GBF word width
- GBF_ADDR_BITWIDTH, 5, GBF address width
- GBF_DEPTH, 32, words per bank and burst length; must equal 2^GBF_ADDR_BITWIDTH

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- need_data  in  4  level requests; [0] actv_gbf1, [1] actv_gbf2, [2] wgt_gbf1, [3] wgt_gbf2
- fill_stop  in  1  level; no new grants while high
- dma_req  out  1  burst request, held until acked
- dma_req_id  out  2  requester index of the held request
- dma_req_ack  in  1  DMA accepts the request
- dma_valid  in  1  stream word valid
- dma_data  in  GBF_DATA_BITWIDTH  stream word
- dma_ready  out  1  arbiter accepts stream word
- en_a  out  4  per-bank port-a enable (same index map as need_data)
- we_a  out  4  per-bank port-a write enable
- addr_a  out  GBF_ADDR_BITWIDTH  shared port-a address
- w_data_a  out  GBF_DATA_BITWIDTH  shared port-a write data
- buf_ready  out  4  one-cycle pulse: bank filled
- actv_data_avail  out  1  filled[0] | filled[1]
- wgt_data_avail  out  1  filled[2] | filled[3]
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, XFER, DONE.
- Eligibility: eligible[i] = need_data[i] & ~filled[i].
- filled[i]:
  - set in DONE for the granted bank;
  - cleared on any cycle where need_data[i] is sampled low.
  - This prevents a refill before the controller drops its request.
- IDLE: if any bank is eligible and fill_stop is low, grant round-robin from pointer ptr, latch gid, and go to REQ. Then ptr = gid+1 mod 4.
- REQ: dma_req=1 and dma_req_id=gid. On dma_req_ack, go to XFER with cnt=0.
- XFER:
  - dma_ready=1.
  - On each dma_valid & dma_ready, write one word at addr cnt, then cnt++.
  - The handshake on the word at cnt==GBF_DEPTH-1 moves the state to DONE.
- DONE: pulse buf_ready[gid], set filled[gid], go to IDLE.
- fill_stop asserted mid-burst has no effect on the current burst. It only blocks the next grant.
- need_data[gid] dropping mid-burst does not abort the burst. The burst completes and filled[gid] is set, then cleared on the next cycle if need_data is still low.
- cnt is GBF_ADDR_BITWIDTH wide and wraps to 0 only via state exit; it never wraps within a burst.
- Words arriving outside XFER are not accepted (dma_ready=0).

## Timing
- Reset values: all outputs 0; state IDLE; ptr=0; filled=0; cnt=0.
- Reset mid-burst clears immediately and abandons the burst. The DMA must be reset together with the arbiter.
- Grant latency: eligible sampled in IDLE at cycle t gives dma_req=1 at cycle t+1 (registered).
- dma_req_ack sampled at cycle t gives dma_ready=1 from cycle t+1.
- Write port is registered: a handshake at cycle t drives en_a[gid]=we_a[gid]=1, addr_a=cnt and w_data_a=dma_data in cycle t+1. en_a/we_a are 0 in all other cycles.
- buf_ready[gid] is high exactly one cycle, the cycle after the last write is presented.
- filled[gid] and the data_avail outputs update in that same cycle.
- The next grant can occur at the earliest one cycle after DONE.
- Minimum burst: GBF_DEPTH+3 cycles from grant to buf_ready with back-to-back valid.

## Configuration
- GBF_FILL_WGT_FIRST_EN defined: fixed priority replaces round-robin. Order is wgt_gbf1, wgt_gbf2, actv_gbf1, actv_gbf2, and ptr is unused. Weights then never starve behind activations.
- Undefined: round-robin as described above.

## Structure
- Package gbf_fill_pkg holds:
  - the state enum;
  - requester index localparams (ACTV1=0, ACTV2=1, WGT1=2, WGT2=3);
  - the requester count NREQ=4.
- Sub-module rr_arbiter4: takes eligible plus ptr and returns a one-hot grant and encoded gid. It contains the GBF_FILL_WGT_FIRST_EN variant.

## Test plan
- Reset, then need_data=4'b0001 and continuous valid with data = word index:
  - dma_req_id=0;
  - 32 writes with en_a=we_a=4'b0001 and addr 0..31 with data 0..31;
  - buf_ready=4'b0001 for exactly one cycle;
  - actv_data_avail=1.
- need_data=4'b1111 held, 4 bursts: grant order 0,1,2,3. With GBF_FILL_WGT_FIRST_EN the order is 2,3,0,1.
- Valid toggling every other cycle: still exactly 32 writes, addr strictly incrementing, no write on invalid cycles.
- need_data[0] held high after fill: no second grant to 0. Drop it one cycle and reassert: filled[0] clears and 0 is re-granted.
- fill_stop raised at write 10: the burst finishes all 32 writes and buf_ready pulses, and no further dma_req follows. Dropping fill_stop resumes grants.
- reset asserted at write 15: all outputs 0 asynchronously, and after release the state is IDLE with ptr=0.
